bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock. Successor to the fixed 10-bit combinational converter: generic input width and digit count, start/busy/done handshake, overflow saturation and a leading-zero blanking mask. Sits between the SRF04 echo-width/distance calculator and the 7-segment display driver.

## Interface
- BIN_W, 16, binary input width (≥ 1)
- DIGITS, 5, number of BCD output digits (≥ 1); fewer than ceil(BIN_W·log10 2) is legal and enables overflow
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  request; sampled only in IDLE
- bin  in  BIN_W  unsigned value; captured on the accepting edge only
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse, results valid and updated
- bcd  out  4·DIGITS  result, digit i at bits [4i+3:4i], digit 0 = ones
- overflow  out  1  value did not fit in DIGITS digits (held with bcd)
- lz  out  DIGITS  lz[i]=1 when digit i and every higher digit are zero; lz[0] always 0

## Operation
- FSM states: IDLE, SHIFT. Reset → IDLE.
- IDLE: start=1 at an edge → load shift register with bin, clear BCD scratch and sticky overflow, bit counter = BIN_W, go SHIFT.
- SHIFT, each edge: every scratch digit ≥ 5 gets +3 (digit adjust), then {scratch, shreg} shifts left by one; bit shifted out of top digit sets sticky overflow; counter decrements.
- On the edge where the final (BIN_W-th) shift occurs: register bcd (or all-9s if overflow, including from that final shift), overflow, lz; pulse done; return to IDLE.
- lz computed from the value registered to bcd (all-9s → lz = 0).
- start while busy: ignored, no queueing; bin changes while busy: no effect.
- Outputs bcd/overflow/lz hold from one done to the next.
- Async reset mid-conversion: conversion abandoned, no done, outputs to reset values.
- Reset values: busy 0, done 0, bcd 0, overflow 0, lz = all ones except lz[0] = 0.

## Timing
- Accept edge k; busy = 1 from after edge k through edge k+BIN_W; done = 1 for exactly the cycle after edge k+BIN_W; busy falls on the same edge done rises.
- Latency: BIN_W clocks from accepting edge to done.
- start held high continuously: next accept at edge k+BIN_W+1 (done cycle sees IDLE); throughput one conversion per BIN_W+1 clocks.
- All outputs registered; no combinational path from start/bin to any output.

## Structure
- Package bcd_pkg: DIGIT_W = 4 constant, state enum {IDLE, SHIFT}, function min_digits(bin_w) for elaboration-time checks/warnings.
- Sub-module bcd_digit_adj: 4-bit combinational +3-if-≥5 corrector, instantiated DIGITS times via generate.
- Counter width clog2(BIN_W+1).

## Test plan
- BIN_W=16, DIGITS=5, bin=0, start one cycle → done exactly 16 clocks after accept, bcd=0x00000, lz=5'b11110, overflow=0.
- BIN_W=16, DIGITS=5, bin=65535 → bcd=0x65535, lz=5'b00000, overflow=0; bin=407 → bcd=0x00407, lz=5'b11000.
- BIN_W=10, DIGITS=3, bin=1000 → overflow=1, bcd=0x999, lz=3'b000; then bin=999 → overflow=0, bcd=0x999.
- start pulsed and bin changed at clocks 3 and 9 of a busy conversion → single done, result of original bin only.
- start held high, bins 123 then 4560 (BIN_W=16) → dones spaced 17 clocks, bcd 0x00123 then 0x04560.
- rst_n low mid-SHIFT for one cycle → busy/done/bcd/overflow immediately 0, lz=5'b11110, no done afterward until new start.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Decimal digits needed to hold 2**bin_w - 1, i.e. ceil(bin_w * log10(2)).
  // 30103/100000 approximates log10(2) closely enough for any practical width.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble corrector: adds 3 to a BCD digit of 5 or more so
// that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Results are saturated to all nines on overflow and come with a leading-zero
// mask so the display driver can blank unused high digits.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      overflow,
  output logic [DIGITS-1:0]         lz
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // With enough digits for the full input range the top digit can never
  // shift a bit out, so the overflow path is tied off and trimmed.
  localparam bit OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

  localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] LZ_RESET  = ~DIGITS'(1);

  state_t             state;
  state_t             state_next;
  logic               load;
  logic               shift_en;
  logic               finish;
  logic               last_bit;

  logic [CNT_W-1:0]   count;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic               ovf_sticky;

  logic [BCD_W-1:0]   adj;
  logic               shift_out;
  logic               ovf_bit;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [BIN_W-1:0]   shreg_nxt;
  logic               ovf_final;
  logic [BCD_W-1:0]   result;
  logic [DIGITS-1:0]  lz_nxt;
  logic               upper_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch[g*DIGIT_W +: DIGIT_W]),
      .adjusted (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign last_bit  = (count == CNT_W'(1));
  assign {shift_out, scratch_nxt, shreg_nxt} = {adj, shreg, 1'b0};
  assign ovf_bit   = OVF_POSSIBLE ? shift_out : 1'b0;
  assign ovf_final = ovf_sticky | ovf_bit;
  assign result    = ovf_final ? ALL_NINES : scratch_nxt;
  assign busy      = (state == SHIFT);

  // FSM state register; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: accept a request only when idle, return after the last bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM control outputs driving the datapath and result registers.
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:  load = start;
      SHIFT: begin
        shift_en = 1'b1;
        finish   = last_bit;
      end
      default: ;
    endcase
  end

  // Conversion datapath: load operand, then adjust-and-shift once per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      shreg      <= '0;
      scratch    <= '0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      count      <= CNT_W'(BIN_W);
      shreg      <= bin;
      scratch    <= '0;
      ovf_sticky <= 1'b0;
    end else if (shift_en) begin
      count      <= count - CNT_W'(1);
      shreg      <= shreg_nxt;
      scratch    <= scratch_nxt;
      ovf_sticky <= ovf_final;
    end
  end

  // Leading-zero mask of the value about to be published; digit 0 never blanks.
  always_comb begin
    lz_nxt     = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (result[DIGIT_W*i +: DIGIT_W] == '0);
      lz_nxt[i]  = upper_zero;
    end
  end

  // Published results: updated only on completion and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      lz       <= LZ_RESET;
    end else begin
      done <= finish;
      if (finish) begin
        bcd      <= result;
        overflow <= ovf_final;
        lz       <= lz_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 16-bit/5-digit instance and a
// 10-bit/3-digit instance (overflow-capable) share one clock and reset.
module tb_bin2bcd_seq;

  localparam int AW = 16;
  localparam int AD = 5;
  localparam int BW = 10;
  localparam int BD = 3;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;

  logic           startA = 1'b0;
  logic [AW-1:0]  binA   = '0;
  logic           busyA, doneA, ovfA;
  logic [4*AD-1:0] bcdA;
  logic [AD-1:0]  lzA;

  logic           startB = 1'b0;
  logic [BW-1:0]  binB   = '0;
  logic           busyB, doneB, ovfB;
  logic [4*BD-1:0] bcdB;
  logic [BD-1:0]  lzB;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [31:0] lz;
    int          doneCyc;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int k;

  bin2bcd_seq #(.BIN_W(AW), .DIGITS(AD)) dutA (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (startA),
    .bin      (binA),
    .busy     (busyA),
    .done     (doneA),
    .bcd      (bcdA),
    .overflow (ovfA),
    .lz       (lzA)
  );

  bin2bcd_seq #(.BIN_W(BW), .DIGITS(BD)) dutB (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (startB),
    .bin      (binB),
    .busy     (busyB),
    .done     (doneB),
    .bcd      (bcdB),
    .overflow (ovfB),
    .lz       (lzB)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time done against the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: decimal digits, saturation and leading-zero mask.
  function automatic exp_t model(input int unsigned v, input int digits, input int doneCyc);
    exp_t        e;
    int unsigned limit = 1;
    int unsigned rem   = v;
    logic        allZero = 1'b1;
    for (int i = 0; i < digits; i++) limit = limit * 10;
    e.bcd = 0;
    e.lz = 0;
    e.doneCyc = doneCyc;
    if (v >= limit) begin
      e.ovf = 1'b1;
      for (int i = 0; i < digits; i++) e.bcd = e.bcd | (32'h9 << (4 * i));
    end else begin
      e.ovf = 1'b0;
      for (int i = 0; i < digits; i++) begin
        e.bcd = e.bcd | ((rem % 10) << (4 * i));
        rem = rem / 10;
      end
    end
    for (int i = digits - 1; i >= 1; i--) begin
      allZero = allZero && (((e.bcd >> (4 * i)) & 32'hF) == 0);
      e.lz[i] = allZero;
    end
    return e;
  endfunction

  // One-cycle start pulse; expectation pushed at the accepting edge.
  task automatic applyStimulus(input bit selB, input int unsigned v, input bit expectDone);
    @(negedge clk);
    if (selB) begin startB = 1'b1; binB = BW'(v); end
    else      begin startA = 1'b1; binA = AW'(v); end
    @(posedge clk);
    #1;
    if (selB) begin
      if (expectDone) qB.push_back(model(v, BD, cyc + BW));
      checkOutput("b_busy_after_accept", 32'(busyB), 32'd1);
    end else begin
      if (expectDone) qA.push_back(model(v, AD, cyc + AW));
      checkOutput("a_busy_after_accept", 32'(busyA), 32'd1);
    end
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    binA   = AW'($urandom);
    binB   = BW'($urandom);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && (qA.size() != 0 || qB.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain_timeout", 32'(qA.size() + qB.size()), 32'd0);
  endtask

  // Scoreboard for instance A: every done must match the oldest expectation.
  always @(negedge clk) begin
    if (doneA) begin
      if (qA.size() == 0) begin
        checkOutput("a_spurious_done", 32'd1, 32'd0);
      end else begin
        eA = qA.pop_front();
        checkOutput("a_bcd", 32'(bcdA), eA.bcd);
        checkOutput("a_overflow", 32'(ovfA), 32'(eA.ovf));
        checkOutput("a_lz", 32'(lzA), eA.lz);
        checkOutput("a_done_cycle", 32'(cyc), 32'(eA.doneCyc));
        checkOutput("a_busy_at_done", 32'(busyA), 32'd0);
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (doneB) begin
      if (qB.size() == 0) begin
        checkOutput("b_spurious_done", 32'd1, 32'd0);
      end else begin
        eB = qB.pop_front();
        checkOutput("b_bcd", 32'(bcdB), eB.bcd);
        checkOutput("b_overflow", 32'(ovfB), 32'(eB.ovf));
        checkOutput("b_lz", 32'(lzB), eB.lz);
        checkOutput("b_done_cycle", 32'(cyc), 32'(eB.doneCyc));
        checkOutput("b_busy_at_done", 32'(busyB), 32'd0);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_bcd", 32'(bcdA), 32'h0);
    checkOutput("rst_overflow", 32'(ovfA), 32'd0);
    checkOutput("rst_lz_a", 32'(lzA), 32'h1E);
    checkOutput("rst_lz_b", 32'(lzB), 32'h6);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic conversions, 16-bit / 5 digits");
    applyStimulus(1'b0, 0, 1'b1);     waitDrain(40);
    applyStimulus(1'b0, 65535, 1'b1); waitDrain(40);
    applyStimulus(1'b0, 407, 1'b1);   waitDrain(40);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, $urandom_range(0, 65535), 1'b1);
      waitDrain(40);
    end

    $display("[TB] overflow, 10-bit / 3 digits");
    applyStimulus(1'b1, 1000, 1'b1); waitDrain(40);
    applyStimulus(1'b1, 999, 1'b1);  waitDrain(40);
    applyStimulus(1'b1, 1023, 1'b1); waitDrain(40);
    applyStimulus(1'b1, 5, 1'b1);    waitDrain(40);

    $display("[TB] start and bin activity while busy");
    applyStimulus(1'b0, 300, 1'b1);
    repeat (2) @(negedge clk);
    startA = 1'b1; binA = 16'd9999;
    @(negedge clk);
    startA = 1'b0;
    repeat (5) @(negedge clk);
    startA = 1'b1; binA = 16'd55555;
    @(negedge clk);
    startA = 1'b0;
    waitDrain(40);
    repeat (20) @(negedge clk);
    checkOutput("a_hold_bcd", 32'(bcdA), 32'h00300);
    checkOutput("a_hold_lz", 32'(lzA), 32'h18);

    $display("[TB] start held high back-to-back");
    @(negedge clk);
    startA = 1'b1; binA = 16'd123;
    @(posedge clk);
    #1;
    k = cyc;
    qA.push_back(model(123, AD, k + AW));
    qA.push_back(model(4560, AD, k + 2 * AW + 1));
    @(negedge clk);
    binA = 16'd4560;
    repeat (AW + 1) @(posedge clk);
    #1;
    checkOutput("a_reaccept_busy", 32'(busyA), 32'd1);
    @(negedge clk);
    startA = 1'b0;
    waitDrain(60);

    $display("[TB] reset in the middle of a conversion");
    applyStimulus(1'b0, 1234, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busyA), 32'd0);
    checkOutput("midrst_done", 32'(doneA), 32'd0);
    checkOutput("midrst_bcd", 32'(bcdA), 32'h0);
    checkOutput("midrst_overflow", 32'(ovfA), 32'd0);
    checkOutput("midrst_lz", 32'(lzA), 32'h1E);
    checkOutput("midrst_bcd_b", 32'(bcdB), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("postrst_busy", 32'(busyA), 32'd0);
    checkOutput("postrst_bcd", 32'(bcdA), 32'h0);

    applyStimulus(1'b0, 42, 1'b1);
    waitDrain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
